// File: rtl/ddr_req_queue.sv
// DDR request queue: validates timestamped requests, buffers them in a
// DEPTH-entry FIFO and retires each one SERVICE_LAT cycles after acceptance
// with bank group / bank / row / column decoded from the address.
// Optional statistics counters are built when DDR_REQ_Q_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
module ddr_req_queue #(
    parameter int DEPTH       = 16,
    parameter int SERVICE_LAT = 100,
    parameter int TIME_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TIME_W-1:0]          in_time,
    input  logic [1:0]                 in_op,
    input  logic [31:0]                in_addr,
    output logic                       out_valid,
    output logic [1:0]                 out_op,
    output logic [31:0]                out_addr,
    output logic [1:0]                 out_bg,
    output logic [1:0]                 out_bank,
    output logic [13:0]                out_row,
    output logic [10:0]                out_col,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       err_op,
    output logic                       err_time,
    output logic [TIME_W-1:0]          stat_accepted,
    output logic [TIME_W-1:0]          stat_retired,
    output logic [TIME_W-1:0]          stat_dropped,
    output logic [$clog2(DEPTH):0]     stat_hwm
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TIME_W-1:0] LAT      = TIME_W'(SERVICE_LAT);

    logic [1:0]        mem_op_r   [DEPTH];
    logic [31:0]       mem_addr_r [DEPTH];
    logic [TIME_W-1:0] mem_dl_r   [DEPTH];

    logic [TIME_W-1:0] now_r;
    logic [TIME_W-1:0] last_time_r;
    logic              have_prev_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;

    logic              hs_s;
    logic              op_bad_s;
    logic              time_bad_s;
    logic              push_s;
    logic              pop_s;
    logic [TIME_W-1:0] head_age_s;
    logic [31:0]       head_addr_s;

    // in_ready depends only on the registered count, so a retire in the same
    // cycle never lets a full queue accept.
    assign in_ready  = (count_r != FULL_CNT);
    assign occupancy = count_r;

    // Handshake qualification: illegal op has priority over timestamp order.
    always_comb begin
        hs_s       = in_valid && in_ready;
        op_bad_s   = hs_s && (in_op == 2'd3);
        time_bad_s = hs_s && !op_bad_s && have_prev_r && (in_time <= last_time_r);
        push_s     = hs_s && !op_bad_s && !time_bad_s;
    end

    // Head is due when (now - deadline) is non-negative in wrap-safe arithmetic.
    always_comb begin
        head_age_s  = now_r - mem_dl_r[rd_ptr_r];
        head_addr_s = mem_addr_r[rd_ptr_r];
        pop_s       = (count_r != {CNT_W{1'b0}}) &&
                      ((head_age_s >> (TIME_W - 1)) == {TIME_W{1'b0}});
    end

    // Next occupancy from push/pop combination.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Queue storage: payload and deadline written at the tail on push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_op_r[wr_ptr_r]   <= in_op;
            mem_addr_r[wr_ptr_r] <= in_addr;
            mem_dl_r[wr_ptr_r]   <= now_r + LAT;
        end else begin
            mem_op_r[wr_ptr_r]   <= mem_op_r[wr_ptr_r];
        end
    end

    // Control state: cycle counter, pointers, occupancy, timestamp history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now_r       <= {TIME_W{1'b0}};
            last_time_r <= {TIME_W{1'b0}};
            have_prev_r <= 1'b0;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else begin
            now_r   <= now_r + TIME_W'(1);
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r    <= wr_ptr_r + PTR_W'(1);
                last_time_r <= in_time;
                have_prev_r <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Registered retire pulse, error pulses and held retire data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            err_op    <= 1'b0;
            err_time  <= 1'b0;
            out_op    <= 2'd0;
            out_addr  <= 32'd0;
            out_bg    <= 2'd0;
            out_bank  <= 2'd0;
            out_row   <= 14'd0;
            out_col   <= 11'd0;
        end else begin
            out_valid <= pop_s;
            err_op    <= op_bad_s;
            err_time  <= time_bad_s;
            if (pop_s) begin
                out_op   <= mem_op_r[rd_ptr_r];
                out_addr <= head_addr_s;
                out_bg   <= head_addr_s[7:6];
                out_bank <= head_addr_s[9:8];
                out_row  <= head_addr_s[31:18];
                out_col  <= {head_addr_s[17:10], head_addr_s[5:3]};
            end
        end
    end

`ifdef DDR_REQ_Q_STATS_EN
    logic [TIME_W-1:0] acc_r;
    logic [TIME_W-1:0] ret_r;
    logic [TIME_W-1:0] drop_r;
    logic [CNT_W-1:0]  hwm_r;

    // Saturating event counters and occupancy high-water mark.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r  <= {TIME_W{1'b0}};
            ret_r  <= {TIME_W{1'b0}};
            drop_r <= {TIME_W{1'b0}};
            hwm_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s && (acc_r != {TIME_W{1'b1}})) begin
                acc_r <= acc_r + TIME_W'(1);
            end
            if (pop_s && (ret_r != {TIME_W{1'b1}})) begin
                ret_r <= ret_r + TIME_W'(1);
            end
            if ((op_bad_s || time_bad_s) && (drop_r != {TIME_W{1'b1}})) begin
                drop_r <= drop_r + TIME_W'(1);
            end
            if (count_nxt_s > hwm_r) begin
                hwm_r <= count_nxt_s;
            end
        end
    end

    assign stat_accepted = acc_r;
    assign stat_retired  = ret_r;
    assign stat_dropped  = drop_r;
    assign stat_hwm      = hwm_r;
`else
    assign stat_accepted = {TIME_W{1'b0}};
    assign stat_retired  = {TIME_W{1'b0}};
    assign stat_dropped  = {TIME_W{1'b0}};
    assign stat_hwm      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ddr_req_queue.sv
// Directed self-checking bench for ddr_req_queue: one default instance
// (DEPTH=16, SERVICE_LAT=100, TIME_W=32) and one narrow-counter instance
// (TIME_W=8) used to exercise deadline comparison across counter wrap.
module tb_ddr_req_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_time;
    logic [1:0]  in_op;
    logic [31:0] in_addr;
    logic        out_valid;
    logic [1:0]  out_op;
    logic [31:0] out_addr;
    logic [1:0]  out_bg;
    logic [1:0]  out_bank;
    logic [13:0] out_row;
    logic [10:0] out_col;
    logic [4:0]  occupancy;
    logic        err_op;
    logic        err_time;
    logic [31:0] stat_accepted;
    logic [31:0] stat_retired;
    logic [31:0] stat_dropped;
    logic [4:0]  stat_hwm;

    logic        rst_n_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [7:0]  in_time_b;
    logic [1:0]  in_op_b;
    logic [31:0] in_addr_b;
    logic        out_valid_b;
    logic [1:0]  out_op_b;
    logic [31:0] out_addr_b;
    logic [1:0]  out_bg_b;
    logic [1:0]  out_bank_b;
    logic [13:0] out_row_b;
    logic [10:0] out_col_b;
    logic [4:0]  occupancy_b;
    logic        err_op_b;
    logic        err_time_b;
    logic [7:0]  stat_accepted_b;
    logic [7:0]  stat_retired_b;
    logic [7:0]  stat_dropped_b;
    logic [4:0]  stat_hwm_b;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_req_queue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid), .out_op(out_op), .out_addr(out_addr),
        .out_bg(out_bg), .out_bank(out_bank), .out_row(out_row), .out_col(out_col),
        .occupancy(occupancy), .err_op(err_op), .err_time(err_time),
        .stat_accepted(stat_accepted), .stat_retired(stat_retired),
        .stat_dropped(stat_dropped), .stat_hwm(stat_hwm)
    );

    ddr_req_queue #(.DEPTH(16), .SERVICE_LAT(100), .TIME_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_time(in_time_b), .in_op(in_op_b), .in_addr(in_addr_b),
        .out_valid(out_valid_b), .out_op(out_op_b), .out_addr(out_addr_b),
        .out_bg(out_bg_b), .out_bank(out_bank_b), .out_row(out_row_b), .out_col(out_col_b),
        .occupancy(occupancy_b), .err_op(err_op_b), .err_time(err_time_b),
        .stat_accepted(stat_accepted_b), .stat_retired(stat_retired_b),
        .stat_dropped(stat_dropped_b), .stat_hwm(stat_hwm_b)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges; the next edge after return has now=0.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 2'd0;
        in_time  = 32'd0;
        in_addr  = 32'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (in_ready !== 1'b1 || occupancy !== 5'd0 || out_valid !== 1'b0 ||
            err_op !== 1'b0 || err_time !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy=%b occ=%0d ov=%b eo=%b et=%b required rdy=1 occ=0 ov=0 eo=0 et=0",
                     in_ready, occupancy, out_valid, err_op, err_time);
        end
        n_checks++;
        if (out_addr !== 32'd0 || out_op !== 2'd0 || out_row !== 14'd0 || out_col !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h op=%0d row=%h col=%h required all 0",
                     out_addr, out_op, out_row, out_col);
        end
    endtask

    task automatic test_single_read();
        int lowbad;
        do_reset();
        in_valid = 1'b1; in_op = 2'd0; in_time = 32'd5; in_addr = 32'h0004_02C8;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 5'd1) begin
            n_fail++;
            $display("FAIL single_occ: got %0d required 1", occupancy);
        end
        lowbad = 0;
        for (int i = 1; i < 100; i++) begin
            step();
            if (out_valid !== 1'b0) lowbad++;
        end
        n_checks++;
        if (lowbad != 0) begin
            n_fail++;
            $display("FAIL single_early: %0d early out_valid cycles, required 0", lowbad);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_op !== 2'd0 || out_addr !== 32'h0004_02C8) begin
            n_fail++;
            $display("FAIL single_retire: ov=%b op=%0d addr=%h required ov=1 op=0 addr=000402c8",
                     out_valid, out_op, out_addr);
        end
        n_checks++;
        if (out_bg !== 2'd3 || out_bank !== 2'd2 || out_row !== 14'h0001 || out_col !== 11'h001) begin
            n_fail++;
            $display("FAIL single_decode: bg=%0d bank=%0d row=%h col=%h required bg=3 bank=2 row=1 col=1",
                     out_bg, out_bank, out_row, out_col);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_bg !== 2'd3 || out_addr !== 32'h0004_02C8 || occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL single_hold: ov=%b bg=%0d addr=%h occ=%0d required ov=0 bg=3 addr=000402c8 occ=0",
                     out_valid, out_bg, out_addr, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        int idx_in;
        int idx_out;
        int exp_edge;
        logic exp_acc;
        do_reset();
        idx_in  = 0;
        idx_out = 0;
        for (int e = 0; e < 215; e++) begin
            in_valid = (idx_in < 20);
            in_op    = 2'd1;
            in_time  = 32'(idx_in + 1);
            in_addr  = 32'h1000_0000 + 32'(idx_in) * 32'h40;
            exp_acc  = (idx_in < 20) && (e < 16 || e >= 101);
            step();
            if (exp_acc) idx_in++;
            if (e == 15 || e == 99) begin
                n_checks++;
                if (in_ready !== 1'b0 || occupancy !== 5'd16) begin
                    n_fail++;
                    $display("FAIL b2b_full@%0d: rdy=%b occ=%0d required rdy=0 occ=16", e, in_ready, occupancy);
                end
            end
            if (e == 100) begin
                n_checks++;
                if (in_ready !== 1'b1 || occupancy !== 5'd15) begin
                    n_fail++;
                    $display("FAIL b2b_reopen: rdy=%b occ=%0d required rdy=1 occ=15", in_ready, occupancy);
                end
            end
            if (out_valid === 1'b1) begin
                exp_edge = (idx_out < 16) ? (100 + idx_out) : (201 + idx_out - 16);
                n_checks++;
                if (out_addr !== 32'h1000_0000 + 32'(idx_out) * 32'h40 || e != exp_edge) begin
                    n_fail++;
                    $display("FAIL b2b_retire%0d: addr=%h edge=%0d required addr=%h edge=%0d", idx_out,
                             out_addr, e, 32'h1000_0000 + 32'(idx_out) * 32'h40, exp_edge);
                end
                idx_out++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (idx_out != 20 || occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_count: retired=%0d occ=%0d required 20 and 0", idx_out, occupancy);
        end
    endtask

    task automatic test_err_op();
        do_reset();
        in_valid = 1'b1; in_op = 2'd3; in_time = 32'd50; in_addr = 32'h0000_1000;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (err_op !== 1'b1 || occupancy !== 5'd0 || err_time !== 1'b0) begin
            n_fail++;
            $display("FAIL errop_pulse: eo=%b occ=%0d et=%b required eo=1 occ=0 et=0", err_op, occupancy, err_time);
        end
        step();
        n_checks++;
        if (err_op !== 1'b0) begin
            n_fail++;
            $display("FAIL errop_clear: got %b required 0", err_op);
        end
        in_valid = 1'b1; in_op = 2'd1; in_time = 32'd50;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 5'd1 || err_op !== 1'b0 || err_time !== 1'b0) begin
            n_fail++;
            $display("FAIL errop_next: occ=%0d eo=%b et=%b required occ=1 eo=0 et=0", occupancy, err_op, err_time);
        end
    endtask

    task automatic test_err_time();
        do_reset();
        in_valid = 1'b1; in_op = 2'd0; in_time = 32'd10; in_addr = 32'h0000_2000;
        step();
        in_time = 32'd10;
        step();
        n_checks++;
        if (err_time !== 1'b1 || occupancy !== 5'd1) begin
            n_fail++;
            $display("FAIL errtime_dup: et=%b occ=%0d required et=1 occ=1", err_time, occupancy);
        end
        in_time = 32'd11;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (err_time !== 1'b0 || occupancy !== 5'd2) begin
            n_fail++;
            $display("FAIL errtime_next: et=%b occ=%0d required et=0 occ=2", err_time, occupancy);
        end
`ifdef DDR_REQ_Q_STATS_EN
        n_checks++;
        if (stat_accepted !== 32'd2 || stat_dropped !== 32'd1 || stat_hwm !== 5'd2) begin
            n_fail++;
            $display("FAIL stats: acc=%0d drop=%0d hwm=%0d required 2 1 2", stat_accepted, stat_dropped, stat_hwm);
        end
`else
        n_checks++;
        if (stat_accepted !== 32'd0 || stat_dropped !== 32'd0 || stat_retired !== 32'd0 || stat_hwm !== 5'd0) begin
            n_fail++;
            $display("FAIL stats_tied: acc=%0d drop=%0d ret=%0d hwm=%0d required all 0",
                     stat_accepted, stat_dropped, stat_retired, stat_hwm);
        end
`endif
    endtask

    task automatic test_wrap();
        int lowbad;
        rst_n_b = 1'b0; in_valid_b = 1'b0; in_op_b = 2'd0; in_time_b = 8'd0; in_addr_b = 32'd0;
        step();
        rst_n_b = 1'b1;
        for (int i = 0; i < 206; i++) step();
        in_valid_b = 1'b1; in_op_b = 2'd2; in_time_b = 8'd1; in_addr_b = 32'hABCD_0040;
        step();
        in_valid_b = 1'b0;
        n_checks++;
        if (occupancy_b !== 5'd1) begin
            n_fail++;
            $display("FAIL wrap_occ: got %0d required 1", occupancy_b);
        end
        lowbad = 0;
        for (int i = 1; i < 100; i++) begin
            step();
            if (out_valid_b !== 1'b0) lowbad++;
        end
        n_checks++;
        if (lowbad != 0) begin
            n_fail++;
            $display("FAIL wrap_early: %0d early out_valid cycles, required 0", lowbad);
        end
        step();
        n_checks++;
        if (out_valid_b !== 1'b1 || out_addr_b !== 32'hABCD_0040 || out_op_b !== 2'd2) begin
            n_fail++;
            $display("FAIL wrap_retire: ov=%b addr=%h op=%0d required ov=1 addr=abcd0040 op=2",
                     out_valid_b, out_addr_b, out_op_b);
        end
        step();
        n_checks++;
        if (out_valid_b !== 1'b0 || occupancy_b !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_after: ov=%b occ=%0d required ov=0 occ=0", out_valid_b, occupancy_b);
        end
    endtask

    task automatic test_flush();
        int lowbad;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_op = 2'd0; in_time = 32'(i + 1);
            in_addr = 32'h2000_0000 + 32'(i) * 32'h8;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 5'd8) begin
            n_fail++;
            $display("FAIL flush_fill: occ=%0d required 8", occupancy);
        end
`ifdef DDR_REQ_Q_STATS_EN
        n_checks++;
        if (stat_hwm !== 5'd8) begin
            n_fail++;
            $display("FAIL flush_hwm_pre: got %0d required 8", stat_hwm);
        end
`endif
        rst_n = 1'b0;
        step();
        n_checks++;
        if (occupancy !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: occ=%0d ov=%b rdy=%b required 0 0 1", occupancy, out_valid, in_ready);
        end
`ifdef DDR_REQ_Q_STATS_EN
        n_checks++;
        if (stat_hwm !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_hwm_post: got %0d required 0", stat_hwm);
        end
`endif
        rst_n = 1'b1;
        in_valid = 1'b1; in_op = 2'd2; in_time = 32'd0; in_addr = 32'h3000_0100;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 5'd1 || err_time !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_t0: occ=%0d et=%b required occ=1 et=0", occupancy, err_time);
        end
        lowbad = 0;
        for (int i = 1; i < 100; i++) begin
            step();
            if (out_valid !== 1'b0) lowbad++;
        end
        n_checks++;
        if (lowbad != 0) begin
            n_fail++;
            $display("FAIL flush_ghost: %0d stray out_valid cycles, required 0", lowbad);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h3000_0100 || out_op !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_retire: ov=%b addr=%h op=%0d required ov=1 addr=30000100 op=2",
                     out_valid, out_addr, out_op);
        end
    endtask

    // Test sequence
    initial begin
        rst_n_b = 1'b0; in_valid_b = 1'b0; in_op_b = 2'd0; in_time_b = 8'd0; in_addr_b = 32'd0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_err_op();
        test_err_time();
        test_wrap();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
